// File: rtl/ctrl_seq_fsm.sv
`default_nettype none
// ============================================================================
// ctrl_seq_fsm : multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer
// Revision 1.0 - initial release
// ============================================================================
module ctrl_seq_fsm #(
    parameter int MEM_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    input  logic [3:0] opcode,
    output logic       instr_ready,
    input  logic       mem_ack,
    output logic       ir_load,
    output logic       pc_inc,
    output logic [2:0] alu_op,
    output logic       mem_req,
    output logic       mem_we,
    output logic [1:0] wa_sel,
    output logic       reg_write,
    output logic       retire,
    output logic       illegal,
    output logic       timeout
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP     = 4'd0;
    localparam logic [3:0] OP_LOADI   = 4'd8;
    localparam logic [3:0] OP_LOAD    = 4'd9;
    localparam logic [3:0] OP_STORE   = 4'd10;
    localparam logic [3:0] OP_JAL     = 4'd11;
    localparam logic [3:0] OP_CLR     = 4'd12;
    localparam logic [3:0] OP_ILL_MIN = 4'd13;

    localparam logic [1:0] WA_RD    = 2'b00;
    localparam logic [1:0] WA_RT    = 2'b01;
    localparam logic [1:0] WA_LINK  = 2'b10;
    localparam logic [1:0] WA_ZERO  = 2'b11;

    // Last wait-counter value before the timeout fires on a missing ack.
    localparam logic [3:0] WAIT_LAST = 4'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [3:0] wait_q, wait_d;
    logic       illegal_q, illegal_d;
    logic       timeout_q, timeout_d;

    logic       w_is_nop;
    logic       w_is_illegal;
    logic       w_is_alu;
    logic       w_is_load;
    logic       w_is_store;
    logic [1:0] w_wa_inst;

    assign w_is_nop     = (op_q == OP_NOP);
    assign w_is_illegal = (op_q >= OP_ILL_MIN);
    assign w_is_alu     = !op_q[3] && !w_is_nop;
    assign w_is_load    = (op_q == OP_LOAD);
    assign w_is_store   = (op_q == OP_STORE);

    // Write-address select is a pure function of the latched opcode, so it
    // stays constant through EXEC, MEM and WB of one instruction.
    always_comb begin
        w_wa_inst = WA_RD;
        case (op_q)
            OP_LOADI, OP_LOAD: w_wa_inst = WA_RT;
            OP_JAL:            w_wa_inst = WA_LINK;
            OP_CLR:            w_wa_inst = WA_ZERO;
            default:           w_wa_inst = WA_RD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= 4'd0;
            wait_q    <= 4'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        wait_d      = wait_q;
        illegal_d   = illegal_q;
        timeout_d   = timeout_q;
        instr_ready = 1'b0;
        ir_load     = 1'b0;
        pc_inc      = 1'b0;
        alu_op      = 3'd0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        wa_sel      = WA_RD;
        reg_write   = 1'b0;
        retire      = 1'b0;

        case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    op_d      = opcode;
                    illegal_d = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                ir_load = 1'b1;
                pc_inc  = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                if (w_is_nop) begin
                    retire  = 1'b1;
                    state_d = IDLE;
                end else if (w_is_illegal) begin
                    illegal_d = 1'b1;
                    retire    = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                wa_sel = w_wa_inst;
                if (w_is_alu) begin
                    alu_op = op_q[2:0];
                end
                wait_d  = 4'd0;
                state_d = (w_is_load || w_is_store) ? MEM : WB;
            end
            MEM: begin
                wa_sel  = w_wa_inst;
                mem_req = 1'b1;
                mem_we  = w_is_store;
                // An ack in the final allowed cycle beats the timeout.
                if (mem_ack) begin
                    if (w_is_store) begin
                        retire  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    retire    = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            WB: begin
                wa_sel    = w_wa_inst;
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign illegal = illegal_q;
    assign timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_seq_fsm.sv
`default_nettype none
// Scoreboard bench for ctrl_seq_fsm: directed test-plan items plus random opcodes.
module tb_ctrl_seq_fsm;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic       mem_ack = 1'b0;
    logic       instr_ready, ir_load, pc_inc, mem_req, mem_we;
    logic       reg_write, retire, illegal, timeout;
    logic [2:0] alu_op;
    logic [1:0] wa_sel;

    ctrl_seq_fsm #(.MEM_TIMEOUT(T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .instr_ready (instr_ready),
        .mem_ack     (mem_ack),
        .ir_load     (ir_load),
        .pc_inc      (pc_inc),
        .alu_op      (alu_op),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .wa_sel      (wa_sel),
        .reg_write   (reg_write),
        .retire      (retire),
        .illegal     (illegal),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        int         ret_cyc;
        int         nwr;
        logic [1:0] wa;
        int         nmem;
        logic       we;
        logic [2:0] alu;
        logic       ill;
        logic       tmo;
    } exp_t;

    exp_t exp_q[$];
    int   nvec  = 0;
    int   nfail = 0;
    int   ack_k = 100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference behaviour: cycle of retire (handshake edge = 0) and what the
    // instruction must have done, derived from the opcode class and ack timing.
    function automatic exp_t model(input logic [3:0] op, input int k);
        exp_t e;
        e.op = op; e.ret_cyc = 0; e.nwr = 0; e.wa = 2'b00; e.nmem = 0;
        e.we = 1'b0; e.alu = 3'd0; e.ill = 1'b0; e.tmo = 1'b0;
        if (op == 4'd0) begin
            e.ret_cyc = 2;
        end else if (op >= 4'd13) begin
            e.ret_cyc = 2; e.ill = 1'b1;
        end else if (op <= 4'd7) begin
            e.ret_cyc = 4; e.nwr = 1; e.alu = op[2:0];
        end else if (op == 4'd8) begin
            e.ret_cyc = 4; e.nwr = 1; e.wa = 2'b01;
        end else if (op == 4'd11) begin
            e.ret_cyc = 4; e.nwr = 1; e.wa = 2'b10;
        end else if (op == 4'd12) begin
            e.ret_cyc = 4; e.nwr = 1; e.wa = 2'b11;
        end else begin
            e.we = (op == 4'd10);
            e.wa = (op == 4'd9) ? 2'b01 : 2'b00;
            if (k <= T) begin
                e.nmem = k;
                if (op == 4'd9) begin
                    e.ret_cyc = 4 + k; e.nwr = 1;
                end else begin
                    e.ret_cyc = 3 + k;
                end
            end else begin
                e.nmem = T; e.ret_cyc = 3 + T; e.tmo = 1'b1;
            end
        end
        return e;
    endfunction

    // Memory responder: acks on the k-th MEM cycle, random noise outside MEM.
    initial begin : responder
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                n++;
                mem_ack = (n == ack_k);
            end else begin
                n = 0;
                mem_ack = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: follows each instruction from ir_load to retire and scores it.
    initial begin : monitor
        bit         active, flag_chk;
        int         rel, nir, npc, nwr, nmem, nrdy;
        logic       we_or;
        logic [2:0] alu_s;
        exp_t       cur;
        active = 0; flag_chk = 0; rel = 0; nir = 0; npc = 0; nwr = 0;
        nmem = 0; nrdy = 0; we_or = 0; alu_s = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                active = 0;
                flag_chk = 0;
                continue;
            end
            if (flag_chk) begin
                check("illegal_flag", illegal, cur.ill);
                check("timeout_flag", timeout, cur.tmo);
                check("ready_after_retire", instr_ready, 1);
                flag_chk = 0;
            end
            if (ir_load && !active) begin
                active = 1; rel = 1; nir = 0; npc = 0; nwr = 0; nmem = 0;
                nrdy = 0; we_or = 0; alu_s = 0;
                check("flags_cleared", {illegal, timeout}, 0);
            end else if (active) begin
                rel++;
            end
            if (active) begin
                nir += ir_load; npc += pc_inc; nwr += reg_write;
                nmem += mem_req; nrdy += instr_ready; we_or |= mem_we;
                if (rel == 3) alu_s = alu_op;
                if (rel > 40) begin
                    check("retire_timeout", rel, 0);
                    active = 0;
                end
            end else begin
                check("idle_reg_write", reg_write, 0);
                check("idle_retire", retire, 0);
            end
            if (active && retire) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", retire, 0);
                end else begin
                    cur = exp_q.pop_front();
                    check("retire_cycle", rel, cur.ret_cyc);
                    check("reg_write_count", nwr, cur.nwr);
                    check("wa_sel", wa_sel, cur.wa);
                    check("mem_req_cycles", nmem, cur.nmem);
                    check("mem_we", we_or, cur.we);
                    check("alu_op", alu_s, cur.alu);
                    check("ir_load_pc_inc", {nir[7:0], npc[7:0]}, 16'h0101);
                    check("busy_ready", nrdy, 0);
                    flag_chk = 1;
                end
                active = 0;
            end
        end
    end

    task automatic issue(input logic [3:0] op, input int k);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!instr_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            check("ready_wait", instr_ready, 1);
            return;
        end
        instr_valid = 1'b1;
        opcode      = op;
        ack_k       = k;
        exp_q.push_back(model(op, k));
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        opcode      = 4'($urandom);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int guard;
        #1;
        check("reset_outputs", {instr_ready, ir_load, pc_inc, alu_op, mem_req, mem_we,
                                wa_sel, reg_write, retire, illegal, timeout}, 14'h2000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue(4'd3, 100);
        issue(4'd11, 100);
        issue(4'd12, 100);
        issue(4'd9, 3);
        issue(4'd10, 3);
        issue(4'd10, 100);
        issue(4'd9, T);
        issue(4'd9, 100);
        issue(4'd14, 100);
        issue(4'd0, 100);
        issue(4'd8, 100);

        // Asynchronous reset while a LOAD waits in MEM.
        issue(4'd9, 100);
        guard = 0;
        while (!mem_req && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("reach_mem", mem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_mem", {instr_ready, mem_req, reg_write, retire, illegal, timeout}, 6'b100000);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(4'd5, 100);

        for (int i = 0; i < 300; i++) begin
            issue(4'($urandom), $urandom_range(1, T + 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (30) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
